// File: rtl/ram_ctrl_pkg.sv
// Shared RAM command opcodes and the arbiter/sequencer state encoding.
// Also imported by the SPI slave so both agree on the two-word command protocol.
package ram_ctrl_pkg;

   localparam logic [1:0] OPC_HOLD_ADDR1 = 2'd0;
   localparam logic [1:0] OPC_WRITE      = 2'd1;
   localparam logic [1:0] OPC_HOLD_ADDR2 = 2'd2;
   localparam logic [1:0] OPC_READ       = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_WAIT,
      ST_RESP
   } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant: combinational one-hot grant, last winner registered on update_i.
// Reset leaves last grant at requester 1 so requester 0 wins the first tie.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid_i,
   input  logic       update_i,
   output logic [1:0] grant_o
);

   logic last_grant_q;

   always_comb begin
      grant_o = 2'b00;
      case (valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_grant_q ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= 1'b1;
      end else if (update_i) begin
         last_grant_q <= grant_o[1];
      end
   end

endmodule

// File: rtl/ram_cmd_arbiter.sv
// Round-robin arbiter/sequencer turning whole read/write transactions into two-word RAM commands.
// Optional read watchdog under macro RD_TIMEOUT_EN (default build: WAIT holds until read data).
module ram_cmd_arbiter
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_SIZE      = 8,
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 req0_valid,
   input  logic                 req0_we,
   input  logic [ADDR_SIZE-1:0] req0_addr,
   input  logic [7:0]           req0_wdata,
   output logic                 req0_ready,
   output logic                 rsp0_valid,
   output logic [7:0]           rsp0_rdata,
   output logic                 rsp0_err,
   input  logic                 req1_valid,
   input  logic                 req1_we,
   input  logic [ADDR_SIZE-1:0] req1_addr,
   input  logic [7:0]           req1_wdata,
   output logic                 req1_ready,
   output logic                 rsp1_valid,
   output logic [7:0]           rsp1_rdata,
   output logic                 rsp1_err,
   output logic                 ram_rx_valid,
   output logic [9:0]           ram_din,
   input  logic [7:0]           ram_dout,
   input  logic                 ram_tx_valid,
   output logic                 busy
);

   arb_state_t           state_q;
   logic                 owner_q;
   logic                 we_q;
   logic [ADDR_SIZE-1:0] addr_q;
   logic [7:0]           wdata_q;
   logic [7:0]           rdata_q;
   logic                 err_q;
   logic [1:0]           grant;
   logic                 idle;
   logic                 accept;
   logic                 resp;
   logic [7:0]           addr_ext;

`ifdef RD_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q;
`endif

   rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid_i  ({req1_valid, req0_valid}),
      .update_i (accept),
      .grant_o  (grant)
   );

   // Gated with rst_n so ready is also low while reset is held.
   assign idle       = (state_q == ST_IDLE) && rst_n;
   assign req0_ready = idle && grant[0];
   assign req1_ready = idle && grant[1];
   assign accept     = req0_ready || req1_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 8'h00;
         rdata_q <= 8'h00;
         err_q   <= 1'b0;
`ifdef RD_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  owner_q <= grant[1];
                  we_q    <= grant[1] ? req1_we    : req0_we;
                  addr_q  <= grant[1] ? req1_addr  : req0_addr;
                  wdata_q <= grant[1] ? req1_wdata : req0_wdata;
                  rdata_q <= 8'h00;
                  err_q   <= 1'b0;
                  state_q <= ST_ADDR;
               end
            end
            ST_ADDR: state_q <= ST_DATA;
            ST_DATA: begin
               state_q <= we_q ? ST_RESP : ST_WAIT;
`ifdef RD_TIMEOUT_EN
               cnt_q   <= '0;
`endif
            end
            ST_WAIT: begin
               // Read data arriving on the expiry cycle takes priority over the timeout.
               if (ram_tx_valid) begin
                  rdata_q <= ram_dout;
                  err_q   <= 1'b0;
                  state_q <= ST_RESP;
               end
`ifdef RD_TIMEOUT_EN
               else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  rdata_q <= 8'hFF;
                  err_q   <= 1'b1;
                  state_q <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      addr_ext                = 8'h00;
      addr_ext[ADDR_SIZE-1:0] = addr_q;
   end

   always_comb begin
      ram_rx_valid = 1'b0;
      ram_din      = 10'h000;
      if (state_q == ST_ADDR) begin
         ram_rx_valid = 1'b1;
         ram_din      = {(we_q ? OPC_HOLD_ADDR1 : OPC_HOLD_ADDR2), addr_ext};
      end else if (state_q == ST_DATA) begin
         ram_rx_valid = 1'b1;
         ram_din      = we_q ? {OPC_WRITE, wdata_q} : {OPC_READ, 8'h00};
      end
   end

   assign busy       = (state_q != ST_IDLE);
   assign resp       = (state_q == ST_RESP);
   assign rsp0_valid = resp && !owner_q;
   assign rsp1_valid = resp && owner_q;
   assign rsp0_rdata = rsp0_valid ? rdata_q : 8'h00;
   assign rsp1_rdata = rsp1_valid ? rdata_q : 8'h00;
`ifdef RD_TIMEOUT_EN
   assign rsp0_err   = rsp0_valid && err_q;
   assign rsp1_err   = rsp1_valid && err_q;
`else
   assign rsp0_err   = 1'b0;
   assign rsp1_err   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_cmd_arbiter.sv
// Scoreboard bench for ram_cmd_arbiter: transaction-level model predicts grants, commands, responses.
// A behavioural RAM answers read commands; a negedge monitor pops and compares everything.
module tb_ram_cmd_arbiter;

   localparam int TO  = 15;
   localparam int BIG = 1 << 30;

   logic       clk;
   logic       rst_n;
   logic       req0_valid, req0_we, req0_ready, rsp0_valid, rsp0_err;
   logic [7:0] req0_addr, req0_wdata, rsp0_rdata;
   logic       req1_valid, req1_we, req1_ready, rsp1_valid, rsp1_err;
   logic [7:0] req1_addr, req1_wdata, rsp1_rdata;
   logic       ram_rx_valid, ram_tx_valid, busy;
   logic [9:0] ram_din;
   logic [7:0] ram_dout;

   ram_cmd_arbiter #(.ADDR_SIZE(8), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
      .ram_rx_valid(ram_rx_valid), .ram_din(ram_din), .ram_dout(ram_dout),
      .ram_tx_valid(ram_tx_valid), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      logic [9:0] din;
      int         due;
   } cmd_t;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      int         due;   // -1: one cycle after the RAM's read-valid pulse
   } rsp_t;

   // Reference model state
   cmd_t       cmd_q[$];
   rsp_t       rsp_q[2][$];
   logic [7:0] ref_mem[256];
   int         next_free = 0;
   bit         last_g    = 1'b1;
   int         rsp_cnt[2];

   // Behavioural RAM state
   logic [7:0] ram_mem[256];
   logic [7:0] ram_addr;
   int         tx_at      = -1;
   int         last_tx    = -100;
   int         max_delay  = 0;
   bit         no_tx      = 1'b0;
   bit         stray_en   = 1'b0;
   bit         pending_rd = 1'b0;

   initial begin
      ram_tx_valid = 1'b0;
      ram_dout     = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && cyc == tx_at) begin
            ram_tx_valid = 1'b1;
            ram_dout     = ram_mem[ram_addr];
            last_tx      = cyc;
            next_free    = cyc + 2;
            pending_rd   = 1'b0;
            tx_at        = -1;
         end else if (stray_en && !pending_rd && !no_tx && $urandom_range(0, 3) == 0) begin
            ram_tx_valid = 1'b1;
            ram_dout     = 8'($urandom);
         end else begin
            ram_tx_valid = 1'b0;
            ram_dout     = 8'h00;
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         check("reset_outputs",
               {22'd0, req0_ready, req1_ready, busy, ram_rx_valid, rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, ram_din == 10'h000, 1'b0},
               {22'd0, 9'b000000001, 1'b0});
      end else begin
         bit   idle, e0, e1, we, vld;
         int   n;
         logic [7:0] a, d, rd;
         logic       er;
         rsp_t r;
         cmd_t c;
         idle = (cyc >= next_free);
         e0 = idle && req0_valid && (!req1_valid || last_g);
         e1 = idle && req1_valid && (!req0_valid || !last_g);
         check("req0_ready", req0_ready, e0);
         check("req1_ready", req1_ready, e1);
         check("busy", busy, !idle);
         if (e0 || e1) begin
            n  = e1 ? 1 : 0;
            we = e1 ? req1_we : req0_we;
            a  = e1 ? req1_addr : req0_addr;
            d  = e1 ? req1_wdata : req0_wdata;
            c.din = {(we ? 2'b00 : 2'b10), a};   c.due = cyc + 1; cmd_q.push_back(c);
            c.din = we ? {2'b01, d} : {2'b11, 8'h00}; c.due = cyc + 2; cmd_q.push_back(c);
            if (we) begin
               ref_mem[a] = d;
               r.rdata = 8'h00; r.err = 1'b0; r.due = cyc + 3;
               next_free = cyc + 4;
            end else if (no_tx) begin
`ifdef RD_TIMEOUT_EN
               r.rdata = 8'hFF; r.err = 1'b1; r.due = cyc + 3 + TO;
               next_free = cyc + 4 + TO;
`else
               r.rdata = 8'h00; r.err = 1'b0; r.due = -1;
               next_free = BIG;
`endif
            end else begin
               r.rdata = ref_mem[a]; r.err = 1'b0; r.due = -1;
               next_free  = BIG;
               pending_rd = 1'b1;
            end
            rsp_q[n].push_back(r);
            last_g = (n == 1);
         end

         if (ram_rx_valid) begin
            if (cmd_q.size() == 0) begin
               check("cmd_unexpected", ram_rx_valid, 1'b0);
            end else begin
               c = cmd_q.pop_front();
               check("cmd_word", ram_din, c.din);
               check("cmd_cycle", cyc, c.due);
            end
            case (ram_din[9:8])
               2'b00, 2'b10: ram_addr = ram_din[7:0];
               2'b01:        ram_mem[ram_addr] = ram_din[7:0];
               default:      if (!no_tx) tx_at = cyc + 1 + $urandom_range(0, max_delay);
            endcase
         end else begin
            check("din_when_idle", ram_din, 10'h000);
         end

         for (int k = 0; k < 2; k++) begin
            vld = (k == 0) ? rsp0_valid : rsp1_valid;
            rd  = (k == 0) ? rsp0_rdata : rsp1_rdata;
            er  = (k == 0) ? rsp0_err   : rsp1_err;
            if (vld) begin
               rsp_cnt[k]++;
               if (rsp_q[k].size() == 0) begin
                  check($sformatf("rsp%0d_unexpected", k), vld, 1'b0);
               end else begin
                  r = rsp_q[k].pop_front();
                  check($sformatf("rsp%0d_rdata", k), rd, r.rdata);
                  check($sformatf("rsp%0d_err", k), er, r.err);
                  check($sformatf("rsp%0d_cycle", k), cyc, (r.due < 0) ? last_tx + 1 : r.due);
               end
            end else begin
               check($sformatf("rsp%0d_quiet", k), {rd, er}, 9'h000);
            end
         end
      end
   end

   task automatic drive(input int n, input bit v, input bit we, input logic [7:0] a, input logic [7:0] d);
      if (n == 0) begin
         req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
      end
   endtask

   task automatic issue(input int n, input bit we, input logic [7:0] a, input logic [7:0] d, input bit keep);
      int  k;
      bit  rdy;
      @(posedge clk);
      #1;
      drive(n, 1'b1, we, a, d);
      k = 0;
      forever begin
         @(negedge clk);
         rdy = (n == 0) ? req0_ready : req1_ready;
         if (rdy) break;
         k++;
         if (k > 300) begin
            check($sformatf("accept_timeout_req%0d", n), rdy, 1'b1);
            break;
         end
      end
      @(posedge clk);
      #1;
      if (!keep) drive(n, 1'b0, 1'b0, 8'($urandom), 8'($urandom));
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      forever begin
         @(negedge clk);
         if (cyc >= next_free && cmd_q.size() == 0 && rsp_q[0].size() == 0 && rsp_q[1].size() == 0) break;
         k++;
         if (k > 500) begin
            check("idle_timeout", busy, 1'b0);
            break;
         end
      end
   endtask

   task automatic model_reset();
      cmd_q.delete();
      rsp_q[0].delete();
      rsp_q[1].delete();
      next_free  = 0;
      last_g     = 1'b1;
      tx_at      = -1;
      pending_rd = 1'b0;
   endtask

   initial begin
      int c0, c1;
      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 256; i++) begin
         ram_mem[i] = 8'($urandom);
         ref_mem[i] = ram_mem[i];
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_rx_valid", ram_rx_valid, 1'b0);
      check("rst_din", ram_din, 10'h000);
      check("rst_rsp", {rsp0_valid, rsp1_valid, rsp0_rdata, rsp1_rdata}, 18'h0);
      rst_n = 1'b1;

      // Directed write then read-back from the other requester
      issue(0, 1'b1, 8'h3C, 8'hA5, 1'b0);
      wait_idle();
      max_delay = 0;
      issue(1, 1'b0, 8'h3C, 8'h00, 1'b0);
      wait_idle();

      // Both requesters continuously valid: writes to 0..3 alternate 0,1,0,1
      c0 = rsp_cnt[0];
      c1 = rsp_cnt[1];
      fork
         begin
            issue(0, 1'b1, 8'h00, 8'($urandom), 1'b1);
            issue(0, 1'b1, 8'h02, 8'($urandom), 1'b0);
         end
         begin
            issue(1, 1'b1, 8'h01, 8'($urandom), 1'b1);
            issue(1, 1'b1, 8'h03, 8'($urandom), 1'b0);
         end
      join
      wait_idle();
      check("alt_rsp_count0", rsp_cnt[0] - c0, 2);
      check("alt_rsp_count1", rsp_cnt[1] - c1, 2);

      // Stray read-valid pulses, plus req0 held while busy
      stray_en = 1'b1;
      repeat (6) @(posedge clk);
      c0 = rsp_cnt[0];
      fork
         issue(1, 1'b1, 8'h10, 8'h5A, 1'b0);
         begin
            repeat (2) @(posedge clk);
            issue(0, 1'b0, 8'h10, 8'h00, 1'b0);
         end
      join
      wait_idle();
      check("held_req_once", rsp_cnt[0] - c0, 1);
      stray_en = 1'b0;

      // Reset in the middle of a read's WAIT state
      no_tx = 1'b1;
      issue(0, 1'b0, 8'h22, 8'h00, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("wait_busy_before_reset", busy, 1'b1);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("abort_outputs", {busy, ram_rx_valid, ram_din, rsp0_valid, rsp1_valid}, 14'h0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      no_tx = 1'b0;
      c0 = rsp_cnt[0];
      repeat (5) @(posedge clk);
      check("no_rsp_after_abort", rsp_cnt[0] - c0, 0);
      max_delay = 3;
      issue(1, 1'b0, 8'h3C, 8'h00, 1'b0);
      wait_idle();

      // Randomized mixed traffic
      stray_en = 1'b1;
      fork
         for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            issue(0, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), 1'b0);
         end
         for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 4)) @(posedge clk);
            issue(1, 1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), 1'b0);
         end
      join
      wait_idle();
      stray_en = 1'b0;

`ifdef RD_TIMEOUT_EN
      // RAM never answers: watchdog response with error
      no_tx = 1'b1;
      issue(0, 1'b0, 8'h07, 8'h00, 1'b0);
      wait_idle();
      no_tx = 1'b0;
`endif

      wait_idle();
      check("cmd_q_drained", cmd_q.size(), 0);
      check("rsp0_q_drained", rsp_q[0].size(), 0);
      check("rsp1_q_drained", rsp_q[1].size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad + 0);
      $finish;
   end

   initial begin
      #500000;
      bad++;
      $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ram_cmd_arbiter.md
Name: ram_cmd_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port RAM command interface.
- Each requester issues whole read or write transactions.
- The block serialises each transaction into the RAM's two-word command protocol: address-capture word, then data/read word.
- For reads, it waits for the RAM's read-valid pulse and returns the byte to the owning requester.
- Sits between system masters (SPI slave path, debug/DMA master) and the RAM, so both share one memory without command interleaving.

Parameters:
- ADDR_SIZE, 8: address width; must match the RAM's ADDR_SIZE.
- TIMEOUT_CYCLES, 15: read watchdog limit in clk cycles; used only with RD_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 transaction request.
- req0_we  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_SIZE  target address.
- req0_wdata  in  8  write byte; ignored for reads.
- req0_ready  out  1  accept strobe; transaction taken when req0_valid & req0_ready.
- rsp0_valid  out  1  one-cycle completion pulse.
- rsp0_rdata  out  8  read byte, valid with rsp0_valid.
- rsp0_err  out  1  timeout flag, valid with rsp0_valid.
- req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, rsp1_valid, rsp1_rdata, rsp1_err: same as requester 0.
- ram_rx_valid  out  1  command strobe to RAM.
- ram_din  out  10  RAM command word: {opcode[1:0], payload[7:0]}.
- ram_dout  in  8  RAM read data.
- ram_tx_valid  in  1  RAM read-data-valid pulse.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; last_grant = 1, so requester 0 wins the first tie.
  - All outputs 0; ram_din = 0.
  - Reset mid-transaction aborts it: no response pulse, and RAM commands stop immediately.
- Opcodes: 00 hold address (write path), 01 write, 10 hold address (read path), 11 read.
- Payload: address is zero-extended to 8 bits.
- FSM states: IDLE, ADDR, DATA, WAIT, RESP.
- IDLE:
  - reqN_ready is combinational: high only for the granted requester, and only when that requester's valid is high.
  - Grant rule: if exactly one requester is valid, it wins. If both are valid, the one not equal to last_grant wins.
  - On accept: latch owner, we, addr and wdata; update last_grant = owner; go to ADDR.
  - Request fields are don't-care after accept.
- ADDR: ram_rx_valid = 1; ram_din = {we ? 00 : 10, addr}; go to DATA.
- DATA:
  - ram_rx_valid = 1.
  - Write: ram_din = {01, wdata}; go to RESP.
  - Read: ram_din = {11, 8'h00}; go to WAIT.
- WAIT:
  - ram_rx_valid = 0.
  - On ram_tx_valid: capture ram_dout; go to RESP.
- RESP:
  - rsp<owner>_valid = 1 for exactly one cycle.
  - rdata = captured byte for reads, 8'h00 for writes; err = 0.
  - Go to IDLE.
  - The non-owner's rsp outputs stay 0.
- ram_rx_valid and ram_din are decoded from registered state, so they are glitch-free.
- ram_din = 0 whenever ram_rx_valid = 0.
- Latency, with accept edge at end of cycle T:
  - Write: commands in T+1 and T+2, rsp in T+3, next accept possible in T+4.
  - Read: commands in T+1 and T+2, RAM tx_valid in T+3, rsp in T+4, next accept possible in T+5.
- A ram_tx_valid pulse outside WAIT is ignored.
- Requests arriving while busy are held off (ready = 0); requesters must keep valid high until accepted.
- Back-to-back requests from both requesters with both continuously valid alternate 0,1,0,1.

Optional Feature:
- Macro RD_TIMEOUT_EN.
- When defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without ram_tx_valid, go to RESP with rsp_err = 1 and rsp_rdata = 8'hFF.
  - ram_tx_valid in the same cycle as expiry wins: normal data, err = 0.
- When undefined: no counter; WAIT holds until ram_tx_valid; rspN_err is tied 0.

Decomposition:
- Shared package ram_ctrl_pkg holds:
  - the opcode localparams OPC_HOLD_ADDR1 = 0, OPC_WRITE = 1, OPC_HOLD_ADDR2 = 2, OPC_READ = 3, also for reuse by the SPI slave;
  - the state enum typedef.
- Sub-module rr_arb2: two-input round-robin grant logic (valid inputs, last_grant register, one-hot grant output, update strobe).
- The FSM and datapath stay in ram_cmd_arbiter.

Test Plan:
- req0 write addr 8'h3C, data 8'hA5 -> ram_din 10'h03C in T+1, 10'h1A5 in T+2, rsp0_valid in T+3, no rsp1.
- req1 read addr 8'h3C after the above, RAM model returns tx_valid one cycle after READ -> ram_din 10'h23C, 10'h300, rsp1_rdata = 8'hA5 in T+4.
- Both valid continuously after reset, writes to addrs 0..3 -> grants 0,1,0,1; each requester gets exactly 2 rsp pulses.
- rst_n low during WAIT of a read -> all outputs 0 immediately; no rsp pulse after release; next request is serviced normally.
- With RD_TIMEOUT_EN, RAM model never asserts tx_valid -> rsp0_valid after 15 WAIT cycles with rsp0_err = 1, rdata = 8'hFF.
- Stray ram_tx_valid in IDLE, plus req0_valid held while busy -> no response, ready stays low until IDLE, and the request is then accepted once.
